game_ctrl_fsm: RTL and testbench
================================

GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 SHALL have parameter H_ACT, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-003 SHALL have parameter DEB_CYCLES, default 500000, clk cycles str must be stable to be accepted.
REQ-004 SHALL have parameter LIVES, default 3, lives loaded at game start (1..7).
REQ-005 SHALL have parameter SCORE_W, default 8, score counter width.
REQ-006 SHALL have parameter OVER_FRAMES, default 60, minimum frames spent in OVER.
REQ-007 SHALL have ports: clk in 1 system/pixel clock; reset in 1 asynchronous, active-low reset.
REQ-008 SHALL have ports: str in 1 raw start/pause button, asynchronous, active-high.
REQ-009 SHALL have ports: pix_y in 10 current HDMI pixel row; hit in 1 score event pulse; miss in 1 life-loss event pulse.
REQ-010 SHALL have outputs: state out 2; run_en out 1; game_clr out 1; frame_tick out 1; score out SCORE_W; lives out 3; border_rgb out 3; led out 1.

Function
REQ-011 SHALL synchronise str through two flops, then debounce (DEB_CYCLES stable samples), then emit a one-cycle press pulse on each debounced rising edge.
REQ-012 SHALL assert frame_tick for exactly one cycle when registered pix_y equals V_ACT-1 and current pix_y differs (end of active frame).
REQ-013 SHALL implement states IDLE=00, PLAY=01, PAUSE=10, OVER=11, all outputs registered, and SHALL update state on the edge where the triggering pulse is high, visible on outputs the same edge.
REQ-014 IDLE: press -> PLAY, score<=0, lives<=LIVES, game_clr high for that one cycle.
REQ-015 PLAY: hit -> score+1, saturating at all-ones; miss -> lives-1; miss with lives==1 -> lives<=0, state OVER.
REQ-016 PLAY: press -> PAUSE unless the same cycle's miss drives OVER (OVER wins, press discarded); hit and miss in one cycle both apply.
REQ-017 PAUSE: hit and miss ignored; press -> PLAY; score and lives held.
REQ-018 OVER: frame counter counts frame_tick from 0; press ignored until count reaches OVER_FRAMES; afterwards press -> IDLE, score and lives held until next start.
REQ-019 run_en SHALL be 1 only in PLAY.
REQ-020 border_rgb SHALL be 010 IDLE, 111 PLAY, 110 PAUSE, 100 OVER.
REQ-021 led SHALL be 0 IDLE, 1 PLAY, toggle every 16 frame_ticks in PAUSE, toggle every 4 frame_ticks in OVER.

Reset
REQ-022 On reset low, asynchronously: state IDLE, score 0, lives 0, run_en 0, game_clr 0, frame_tick 0, border_rgb 010, led 0, debouncer and frame counters 0, debounced level 0.
REQ-023 Reset mid-game SHALL discard any press in flight; a button held across reset release SHALL NOT produce a press until released and pressed again.

Configuration
REQ-024 With GAME_CTRL_DEBOUNCE_EN defined, debounce per REQ-011; without it, the press pulse SHALL be the rising edge of the 2-flop synchronised str (no stability count, DEB_CYCLES unused).

Structure
REQ-025 Package game_pkg SHALL hold state encodings, H_ACT/V_ACT defaults and the border colour constants.
REQ-026 Debounce plus edge detect SHALL be sub-module btn_debounce; FSM, counters and frame detect stay in game_ctrl_fsm.

Verification (DEB_CYCLES=4, OVER_FRAMES=3, LIVES=3)
REQ-027 str bounce 1-0-1 at 1-cycle spacing then held 10 cycles -> exactly one press, state IDLE->PLAY, game_clr one cycle, lives=3, score=0.
REQ-028 PLAY, 300 hit pulses with SCORE_W=8 -> score saturates at 255.
REQ-029 PLAY lives=1, miss and press same cycle -> state OVER, lives=0, border_rgb=100, no PAUSE.
REQ-030 OVER, press after 2 frame_ticks -> stays OVER; press after 3rd frame_tick -> IDLE.
REQ-031 PLAY -> press -> PAUSE, hit/miss pulses ignored, led toggles after 16 frame_ticks; press -> PLAY with score/lives unchanged.
REQ-032 Reset asserted in PLAY with str held -> all outputs at reset values; after release no press until str low then high.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and constants for the game controller.
package game_pkg;

  localparam int unsigned H_ACT_DEF = 640;
  localparam int unsigned V_ACT_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [2:0] BORDER_IDLE  = 3'b010;
  localparam logic [2:0] BORDER_PLAY  = 3'b111;
  localparam logic [2:0] BORDER_PAUSE = 3'b110;
  localparam logic [2:0] BORDER_OVER  = 3'b100;

  function automatic logic [2:0] border_of(input state_t s);
    case (s)
      ST_IDLE:  border_of = BORDER_IDLE;
      ST_PLAY:  border_of = BORDER_PLAY;
      ST_PAUSE: border_of = BORDER_PAUSE;
      default:  border_of = BORDER_OVER;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start button synchroniser, optional debouncer (GAME_CTRL_DEBOUNCE_EN) and press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic str,
  output logic press
);

  logic s1;
  logic s2;

  // Synchroniser resets to "pressed" so a button held through reset is not a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= str;
      s2 <= s1;
    end
  end

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             deb_lvl;
  logic             armed;
  logic             accept_c;

  assign accept_c = (s2 != deb_lvl) && (cnt == CNT_W'(DEB_CYCLES - 1));

  // Accept a new level after DEB_CYCLES consecutive differing samples; arm once released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      deb_lvl <= 1'b0;
      armed   <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= accept_c && s2 && armed;
      if (!s2) armed <= 1'b1;
      if (accept_c) begin
        deb_lvl <= s2;
        cnt     <= '0;
      end else if (s2 != deb_lvl) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  logic prev;
  logic unused_deb;

  assign unused_deb = ^DEB_CYCLES;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev  <= 1'b1;
      press <= 1'b0;
    end else begin
      prev  <= s2;
      press <= s2 && !prev;
    end
  end
`endif

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game control FSM: start/pause handling, score/lives, frame tick and status outputs.
// Debounce of the start button is enabled with GAME_CTRL_DEBOUNCE_EN.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned OVER_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               str,
  input  logic [9:0]         pix_y,
  input  logic               hit,
  input  logic               miss,
  output logic [1:0]         state,
  output logic               run_en,
  output logic               game_clr,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [2:0]         border_rgb,
  output logic               led
);

  localparam int unsigned OVC_W = $clog2(OVER_FRAMES + 1);

  logic               press;
  logic [9:0]         pix_y_q;
  state_t             state_q;
  state_t             state_n;
  logic [SCORE_W-1:0] score_n;
  logic [2:0]         lives_n;
  logic [OVC_W-1:0]   over_cnt_q;
  logic [OVC_W-1:0]   over_cnt_n;
  logic [3:0]         led_cnt_q;
  logic [3:0]         led_cnt_n;
  logic               led_n;
  logic               game_clr_n;
  logic               unused_params;

  assign unused_params = ^H_ACT;
  assign state         = state_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .str   (str),
    .press (press)
  );

  // End of active frame: last active row just left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_y_q    <= '0;
      frame_tick <= 1'b0;
    end else begin
      pix_y_q    <= pix_y;
      frame_tick <= (pix_y_q == 10'(V_ACT - 1)) && (pix_y != pix_y_q);
    end
  end

  always_comb begin
    state_n    = state_q;
    score_n    = score;
    lives_n    = lives;
    over_cnt_n = over_cnt_q;
    led_cnt_n  = led_cnt_q;
    led_n      = led;
    game_clr_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_n    = ST_PLAY;
          score_n    = '0;
          lives_n    = 3'(LIVES);
          game_clr_n = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit && (score != '1)) score_n = score + SCORE_W'(1);
        // Losing the last life takes priority over a same-cycle pause request.
        if (miss && (lives <= 3'd1)) begin
          lives_n = '0;
          state_n = ST_OVER;
        end else begin
          if (miss)  lives_n = lives - 3'd1;
          if (press) state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (press) state_n = ST_PLAY;
      end
      ST_OVER: begin
        if (frame_tick && (over_cnt_q != OVC_W'(OVER_FRAMES))) over_cnt_n = over_cnt_q + OVC_W'(1);
        if (press && (over_cnt_q == OVC_W'(OVER_FRAMES))) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Frame/blink counters restart on every state change.
    if (state_n != state_q) begin
      over_cnt_n = '0;
      led_cnt_n  = '0;
    end else if (frame_tick) begin
      led_cnt_n = led_cnt_q + 4'd1;
    end

    case (state_n)
      ST_IDLE:  led_n = 1'b0;
      ST_PLAY:  led_n = 1'b1;
      ST_PAUSE: if ((state_n == state_q) && frame_tick && (led_cnt_q == 4'd15)) led_n = ~led;
      default:  if ((state_n == state_q) && frame_tick && (led_cnt_q[1:0] == 2'd3)) led_n = ~led;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      score      <= '0;
      lives      <= '0;
      over_cnt_q <= '0;
      led_cnt_q  <= '0;
      led        <= 1'b0;
      game_clr   <= 1'b0;
      run_en     <= 1'b0;
      border_rgb <= BORDER_IDLE;
    end else begin
      state_q    <= state_n;
      score      <= score_n;
      lives      <= lives_n;
      over_cnt_q <= over_cnt_n;
      led_cnt_q  <= led_cnt_n;
      led        <= led_n;
      game_clr   <= game_clr_n;
      run_en     <= (state_n == ST_PLAY);
      border_rgb <= border_of(state_n);
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm (DEB_CYCLES=4, OVER_FRAMES=3, LIVES=3).
module tb_game_ctrl_fsm;

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam int PRESS_LAT = 6;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       str;
  logic [9:0] pix_y;
  logic       hit;
  logic       miss;
  logic [1:0] state;
  logic       run_en;
  logic       game_clr;
  logic       frame_tick;
  logic [7:0] score;
  logic [2:0] lives;
  logic [2:0] border_rgb;
  logic       led;

  int total = 0;
  int bad = 0;
  int clr_seen = 0;

  typedef struct {
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [2:0] lives;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[5];

  game_ctrl_fsm #(
    .DEB_CYCLES (4),
    .LIVES      (3),
    .SCORE_W    (8),
    .OVER_FRAMES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .str        (str),
    .pix_y      (pix_y),
    .hit        (hit),
    .miss       (miss),
    .state      (state),
    .run_en     (run_en),
    .game_clr   (game_clr),
    .frame_tick (frame_tick),
    .score      (score),
    .lives      (lives),
    .border_rgb (border_rgb),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (game_clr === 1'b1) clr_seen++;
    end
  endtask

  task automatic press_btn();
    str = 1'b1;
    cyc(10);
    str = 1'b0;
    cyc(10);
  endtask

  task automatic frame();
    pix_y = 10'd479;
    cyc(1);
    pix_y = 10'd0;
    cyc(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 2'b00);
    chk({tag, "_score"}, score, 8'd0);
    chk({tag, "_lives"}, lives, 3'd0);
    chk({tag, "_run_en"}, run_en, 1'b0);
    chk({tag, "_game_clr"}, game_clr, 1'b0);
    chk({tag, "_frame_tick"}, frame_tick, 1'b0);
    chk({tag, "_border"}, border_rgb, 3'b010);
    chk({tag, "_led"}, led, 1'b0);
  endtask

  initial begin
    vecs[0] = '{hit: 1'b1, miss: 1'b0, score: 8'd1, lives: 3'd3, state: 2'b01};
    vecs[1] = '{hit: 1'b0, miss: 1'b1, score: 8'd1, lives: 3'd2, state: 2'b01};
    vecs[2] = '{hit: 1'b1, miss: 1'b1, score: 8'd2, lives: 3'd1, state: 2'b01};
    vecs[3] = '{hit: 1'b0, miss: 1'b0, score: 8'd2, lives: 3'd1, state: 2'b01};
    vecs[4] = '{hit: 1'b1, miss: 1'b0, score: 8'd3, lives: 3'd1, state: 2'b01};

    reset = 1'b0;
    str   = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
    pix_y = 10'd0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    cyc(5);

    // Start: bouncy press with debounce, clean press otherwise
    clr_seen = 0;
`ifdef GAME_CTRL_DEBOUNCE_EN
    str = 1'b1; cyc(1);
    str = 1'b0; cyc(1);
    str = 1'b1; cyc(10);
    str = 1'b0; cyc(10);
`else
    press_btn();
`endif
    chk("start_clr_pulses", clr_seen, 1);
    chk("start_state", state, 2'b01);
    chk("start_lives", lives, 3'd3);
    chk("start_score", score, 8'd0);
    chk("start_run_en", run_en, 1'b1);
    chk("start_border", border_rgb, 3'b111);
    chk("start_led", led, 1'b1);

    for (int i = 0; i < 5; i++) begin
      hit  = vecs[i].hit;
      miss = vecs[i].miss;
      cyc(1);
      hit  = 1'b0;
      miss = 1'b0;
      chk($sformatf("vec%0d_score", i), score, vecs[i].score);
      chk($sformatf("vec%0d_lives", i), lives, vecs[i].lives);
      chk($sformatf("vec%0d_state", i), state, vecs[i].state);
    end

    // Last-life miss coinciding with press
    str = 1'b1;
    cyc(PRESS_LAT);
    miss = 1'b1;
    cyc(1);
    miss = 1'b0;
    chk("over_state", state, 2'b11);
    chk("over_lives", lives, 3'd0);
    chk("over_border", border_rgb, 3'b100);
    chk("over_run_en", run_en, 1'b0);
    cyc(5);
    str = 1'b0;
    cyc(10);
    chk("over_no_pause", state, 2'b11);
    chk("over_score_held", score, 8'd3);

    // Frame tick pulse shape
    pix_y = 10'd479;
    cyc(1);
    chk("ft_before", frame_tick, 1'b0);
    pix_y = 10'd0;
    cyc(1);
    chk("ft_pulse", frame_tick, 1'b1);
    cyc(1);
    chk("ft_after", frame_tick, 1'b0);
    frame();
    press_btn();
    chk("over_2frames_press", state, 2'b11);
    frame();
    chk("over_led_3ticks", led, 1'b1);
    frame();
    chk("over_led_4ticks", led, 1'b0);
    press_btn();
    chk("over_exit_state", state, 2'b00);
    chk("idle_score_held", score, 8'd3);
    chk("idle_lives_held", lives, 3'd0);
    chk("idle_border", border_rgb, 3'b010);
    chk("idle_led", led, 1'b0);

    clr_seen = 0;
    press_btn();
    chk("restart_clr", clr_seen, 1);
    chk("restart_state", state, 2'b01);
    chk("restart_score", score, 8'd0);
    chk("restart_lives", lives, 3'd3);

    // Pause: events ignored, slow blink
    press_btn();
    chk("pause_state", state, 2'b10);
    chk("pause_border", border_rgb, 3'b110);
    chk("pause_run_en", run_en, 1'b0);
    chk("pause_led", led, 1'b1);
    hit  = 1'b1;
    miss = 1'b1;
    cyc(3);
    hit  = 1'b0;
    miss = 1'b0;
    chk("pause_score", score, 8'd0);
    chk("pause_lives", lives, 3'd3);
    repeat (15) frame();
    chk("pause_led_15", led, 1'b1);
    frame();
    chk("pause_led_16", led, 1'b0);
    press_btn();
    chk("resume_state", state, 2'b01);
    chk("resume_score", score, 8'd0);
    chk("resume_lives", lives, 3'd3);
    chk("resume_led", led, 1'b1);

    // Score saturation
    hit = 1'b1;
    cyc(254);
    chk("score_254", score, 8'd254);
    cyc(1);
    chk("score_255", score, 8'd255);
    cyc(45);
    hit = 1'b0;
    cyc(1);
    chk("score_sat", score, 8'd255);
    chk("sat_lives", lives, 3'd3);

    // Reset mid-game with button held
    str = 1'b1;
    cyc(3);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cyc(2);
    reset = 1'b1;
    clr_seen = 0;
    cyc(20);
    chk("held_no_press", state, 2'b00);
    chk("held_no_clr", clr_seen, 0);
    str = 1'b0;
    cyc(10);
    press_btn();
    chk("repress_state", state, 2'b01);
    chk("repress_clr", clr_seen, 1);
    chk("repress_lives", lives, 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
